gray_to_binary_tracker: RTL and testbench
=========================================

Name: gray_to_binary_tracker

Overview:
Receives a gray-coded count, one sample per `g_valid` strobe. It converts each sample to binary and classifies the move from the previous accepted sample as one of: hold, step up, step down, or illegal multi-bit jump. It is the decode-side counterpart of the team's binary-to-gray encoder, used for gray-coded pointers and position counters. Illegal jumps are counted in a saturating error counter.

Parameters:
- WIDTH, 4, width of the gray input and binary output.
- ERR_W, 8, width of the saturating jump-error counter.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- g_valid  input  1  strobe: g is sampled on this cycle.
- g  input  WIDTH  gray-coded count.
- err_clr  input  1  synchronous clear of err_count.
- b  output  WIDTH  binary value of the last accepted g (registered).
- b_valid  output  1  one-cycle pulse: b and the flags below were updated.
- step_up  output  1  pulse with b_valid: value incremented by 1 (mod 2^WIDTH).
- step_dn  output  1  pulse with b_valid: value decremented by 1 (mod 2^WIDTH).
- jump_err  output  1  pulse with b_valid: more than one gray bit changed.
- err_count  output  ERR_W  saturating count of jump_err events.
- locked  output  1  high once a first sample has been accepted (state TRACK).

Behaviour:
- Reset (rst_n low at a clk edge):
  - Outputs: b=0, b_valid=0, step_up=0, step_dn=0, jump_err=0, err_count=0, locked=0.
  - Internal: prev_g=0, state=IDLE.
  - Reset mid-stream discards the sample presented that cycle.
- Conversion:
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i], for i from WIDTH-2 down to 0.
- Latency: 1 cycle. g sampled at edge N with g_valid=1 gives b, b_valid and the flags valid after edge N.
- Pulse width: b_valid and the flags are single-cycle pulses and are 0 on cycles without g_valid.
- State IDLE:
  - On g_valid: update b and prev_g, pulse b_valid with all flags 0, go to TRACK, locked=1.
- State TRACK, on g_valid, with d = popcount(g XOR prev_g):
  - d=0: b_valid only. Hold, no flags.
  - d=1: if bin(g) == bin(prev_g)+1 mod 2^WIDTH, step_up=1; otherwise step_dn=1. Wrap-around is legal: 15→0 is up, 0→15 is down.
  - d>=2: jump_err=1. b and prev_g still update to the new sample, so tracking resynchronises.
  - In every case: b <= bin(g), prev_g <= g.
- Flag exclusivity: at most one of step_up, step_dn, jump_err is high in any cycle.
- err_count:
  - Increments on each jump_err.
  - Saturates at 2^ERR_W-1 and never wraps.
- err_clr:
  - Sets err_count to 0 at the next edge.
  - If asserted in the same cycle as a jump_err, the clear wins: err_count=0 and the jump_err pulse still occurs.
  - Does not affect state, b or prev_g.
- TRACK persists until reset; there is no return to IDLE otherwise.
- Inputs on cycles with g_valid=0 are ignored.

Test Plan:
- Reset, then g_valid with g=0000, 0001, 0011, 0010 (binary 0..3) → b=0,1,2,3 each one cycle later. b_valid pulses each time, with step_up=1 on the last three and no flags on the first. locked=1 after the first sample.
- From g=1000 (15), apply g=0000 → b=0, step_up=1. Then g=1000 again → b=15, step_dn=1.
- From g=0111 (5), apply g=0101 (6) → step_up=1. Then g=0111 → step_dn=1. Then g=0111 again → b_valid=1 with no flags.
- From g=0000, apply g=0110 (4) → jump_err=1, b=4, err_count=1. A following g=0111 (5) → step_up=1, confirming resync.
- Force 300 jump errors with ERR_W=8 → err_count holds at 255. Then err_clr together with a further jump → err_count=0 and jump_err=1.
- Drive rst_n low while in TRACK with g_valid=1 → the next cycle shows b=0, b_valid=0, locked=0, err_count=0. The next sample is treated as first (no flags).

Source files
------------

// File: rtl/gray_to_binary_tracker.sv
// Gray-coded count decoder: converts each strobed sample to binary and classifies the move
// from the previous sample (hold / up / down / illegal jump). 1-cycle latency, no backpressure.
module gray_to_binary_tracker #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             g_valid,
   input  logic [WIDTH-1:0] g,
   input  logic             err_clr,
   output logic [WIDTH-1:0] b,
   output logic             b_valid,
   output logic             step_up,
   output logic             step_dn,
   output logic             jump_err,
   output logic [ERR_W-1:0] err_count,
   output logic             locked
);

   typedef enum logic {IDLE, TRACK} state_t;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gv);
      logic [WIDTH-1:0] bv;
      bv[WIDTH-1] = gv[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         bv[i] = bv[i+1] ^ gv[i];
      end
      return bv;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_g_q, prev_g_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             b_valid_q, b_valid_d;
   logic             step_up_q, step_up_d;
   logic             step_dn_q, step_dn_d;
   logic             jump_err_q, jump_err_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic [WIDTH-1:0] g_bin;
   logic [WIDTH-1:0] prev_bin;
   logic [WIDTH-1:0] diff;
   logic             one_bit;
   logic             multi_bit;

   // A non-zero diff with a single set bit is exactly one gray transition.
   always_comb begin
      g_bin     = gray2bin(g);
      prev_bin  = gray2bin(prev_g_q);
      diff      = g ^ prev_g_q;
      one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
      multi_bit = (diff & (diff - WIDTH'(1))) != '0;
   end

   always_comb begin
      state_d    = state_q;
      prev_g_d   = prev_g_q;
      b_d        = b_q;
      b_valid_d  = 1'b0;
      step_up_d  = 1'b0;
      step_dn_d  = 1'b0;
      jump_err_d = 1'b0;

      if (g_valid) begin
         b_d       = g_bin;
         prev_g_d  = g;
         b_valid_d = 1'b1;
         case (state_q)
            IDLE: begin
               state_d = TRACK;
            end
            TRACK: begin
               if (one_bit) begin
                  if (g_bin == prev_bin + WIDTH'(1)) begin
                     step_up_d = 1'b1;
                  end else begin
                     step_dn_d = 1'b1;
                  end
               end else if (multi_bit) begin
                  jump_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Clear takes priority over a simultaneous jump; the count never wraps.
   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = '0;
      end else if (jump_err_d && (err_q != '1)) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prev_g_q   <= '0;
         b_q        <= '0;
         b_valid_q  <= 1'b0;
         step_up_q  <= 1'b0;
         step_dn_q  <= 1'b0;
         jump_err_q <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         prev_g_q   <= prev_g_d;
         b_q        <= b_d;
         b_valid_q  <= b_valid_d;
         step_up_q  <= step_up_d;
         step_dn_q  <= step_dn_d;
         jump_err_q <= jump_err_d;
         err_q      <= err_d;
      end
   end

   assign b         = b_q;
   assign b_valid   = b_valid_q;
   assign step_up   = step_up_q;
   assign step_dn   = step_dn_q;
   assign jump_err  = jump_err_q;
   assign err_count = err_q;
   assign locked    = (state_q == TRACK);

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Scoreboard bench for gray_to_binary_tracker: expected results queued at drive time,
// popped and compared when b_valid appears.
module tb_gray_to_binary_tracker;

   localparam int WIDTH = 4;
   localparam int ERR_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             g_valid;
   logic [WIDTH-1:0] g;
   logic             err_clr;
   logic [WIDTH-1:0] b;
   logic             b_valid;
   logic             step_up;
   logic             step_dn;
   logic             jump_err;
   logic [ERR_W-1:0] err_count;
   logic             locked;

   gray_to_binary_tracker #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .g_valid   (g_valid),
      .g         (g),
      .err_clr   (err_clr),
      .b         (b),
      .b_valid   (b_valid),
      .step_up   (step_up),
      .step_dn   (step_dn),
      .jump_err  (jump_err),
      .err_count (err_count),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] b;
      logic             up;
      logic             dn;
      logic             jmp;
      logic [ERR_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // model state
   logic [WIDTH-1:0] m_prev;
   logic             m_locked;
   int               m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] x);
      return x ^ (x >> 1) ^ (x >> 2) ^ (x >> 3);
   endfunction

   function automatic int ones(input logic [WIDTH-1:0] x);
      int n = 0;
      for (int i = 0; i < WIDTH; i++) n += int'(x[i]);
      return n;
   endfunction

   // Monitor: compares every valid output against the queue head.
   always @(posedge clk) begin
      #1;
      if (b_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_b_valid", 32'(b_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("b", 32'(b), 32'(e.b));
            chk("step_up", 32'(step_up), 32'(e.up));
            chk("step_dn", 32'(step_dn), 32'(e.dn));
            chk("jump_err", 32'(jump_err), 32'(e.jmp));
            chk("err_count", 32'(err_count), 32'(e.cnt));
         end
      end else if (step_up || step_dn || jump_err) begin
         chk("flags_without_valid", 32'({step_up, step_dn, jump_err}), 32'd0);
      end
   end

   task automatic model_reset();
      m_prev   = '0;
      m_locked = 1'b0;
      m_cnt    = 0;
   endtask

   task automatic send(input logic [WIDTH-1:0] gv, input logic clr);
      exp_t e;
      int   d;
      @(negedge clk);
      g_valid = 1'b1;
      g       = gv;
      err_clr = clr;
      e       = '0;
      e.b     = g2b(gv);
      if (m_locked) begin
         d = ones(gv ^ m_prev);
         if (d == 1) begin
            if (g2b(gv) == WIDTH'(g2b(m_prev) + 1)) e.up = 1'b1;
            else e.dn = 1'b1;
         end else if (d >= 2) begin
            e.jmp = 1'b1;
         end
      end
      if (clr) m_cnt = 0;
      else if (e.jmp && m_cnt < (1 << ERR_W) - 1) m_cnt++;
      e.cnt    = ERR_W'(m_cnt);
      m_prev   = gv;
      m_locked = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      g_valid = 1'b0;
      err_clr = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      g_valid = 1'b0;
      g       = '0;
      err_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_b", 32'(b), 32'd0);
      chk("rst_b_valid", 32'(b_valid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);

      // count 0..3
      send(4'b0000, 1'b0);
      chk("locked_after_first", 32'(locked), 32'd1);
      send(4'b0001, 1'b0);
      send(4'b0011, 1'b0);
      send(4'b0010, 1'b0);

      // wrap 15 -> 0 -> 15
      send(4'b1000, 1'b0);
      send(4'b0000, 1'b0);
      send(4'b1000, 1'b0);

      // 5 -> 6 -> 5 -> 5
      send(4'b0111, 1'b0);
      send(4'b0101, 1'b0);
      send(4'b0111, 1'b0);
      send(4'b0111, 1'b0);

      // jump and resync
      send(4'b0000, 1'b0);
      send(4'b0110, 1'b0);
      chk("jump_b", 32'(b), 32'd4);
      send(4'b0111, 1'b0);

      // saturation
      for (int i = 0; i < 150; i++) begin
         send(4'b0000, 1'b0);
         send(4'b0110, 1'b0);
      end
      chk("sat_count", 32'(err_count), 32'd255);
      send(4'b0000, 1'b1);
      chk("clr_wins", 32'(err_count), 32'd0);

      // random walk with gaps
      for (int i = 0; i < 60; i++) begin
         send(WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 9) == 0));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // reset mid-stream with a sample presented
      @(negedge clk);
      rst_n   = 1'b0;
      g_valid = 1'b1;
      g       = 4'b0101;
      @(negedge clk);
      rst_n   = 1'b1;
      g_valid = 1'b0;
      model_reset();
      chk("midrst_b", 32'(b), 32'd0);
      chk("midrst_b_valid", 32'(b_valid), 32'd0);
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_err_count", 32'(err_count), 32'd0);
      send(4'b1100, 1'b0);
      send(4'b1101, 1'b0);

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
